// File: rtl/std_mem_stream_pkg.sv
// Shared types for the std_mem_d1 read streamer.
// Contents:
//   stream_state_e : controller state (IDLE, STREAM, DONE)
package std_mem_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } stream_state_e;

endpackage

// File: rtl/std_wrap_counter.sv
// Address register that counts modulo SIZE.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   load       : load count with load_val (wins over inc)
//   load_val   : value to load
//   inc        : advance count by one, wrapping from SIZE-1 to 0
//   count      : current address
module std_wrap_counter #(
  parameter int IDX_SIZE = 4,
  parameter int SIZE     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [IDX_SIZE-1:0] load_val,
  input  logic                inc,
  output logic [IDX_SIZE-1:0] count
);

  // Explicit compare against SIZE-1 so non-power-of-two sizes wrap correctly.
  localparam logic [IDX_SIZE-1:0] LAST = IDX_SIZE'(SIZE - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= (count == LAST) ? '0 : count + IDX_SIZE'(1);
    end
  end

endmodule

// File: rtl/std_mem_d1_streamer.sv
// Read-side initiator for a std_mem_d1 memory: on go, walks a wrapping
// address range and emits each word on a valid/ready stream, then pulses done.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   go            : start request, sampled only in IDLE
//   start_addr    : first address, sampled with go (must be < SIZE)
//   len           : word count, sampled with go, clamped to SIZE
//   mem_addr0     : address to the memory (combinational read)
//   mem_read_data : read data from the memory
//   out_data      : stream payload
//   out_valid     : payload valid
//   out_ready     : consumer ready
//   busy          : high in STREAM and DONE
//   done          : one-cycle completion pulse
//   dbg_state     : current controller state
//
// Stream handshake: a word transfers on every rising edge where
// out_valid && out_ready. Once out_valid is high, out_data and out_valid stay
// stable until that transfer; out_valid never depends on out_ready.
module std_mem_d1_streamer
  import std_mem_stream_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE-1:0] start_addr,
  input  logic [IDX_SIZE:0]   len,
  output logic [IDX_SIZE-1:0] mem_addr0,
  input  logic [WIDTH-1:0]    mem_read_data,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output stream_state_e       dbg_state
);

  localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE + 1)'(SIZE);

  stream_state_e       state;
  logic [IDX_SIZE:0]   remaining;
  logic [IDX_SIZE:0]   len_clamped;
  logic                start;
  logic                load;
  logic                hs;

  assign len_clamped = (len > SIZE_W) ? SIZE_W : len;
  assign start       = (state == IDLE) && go;
  // Load whenever a word is left and the holding register is empty or
  // draining this cycle; this keeps one word per cycle under ready=1.
  assign load        = (state == STREAM) && (remaining != '0) &&
                       (!out_valid || out_ready);
  assign hs          = out_valid && out_ready;

  std_wrap_counter #(
    .IDX_SIZE(IDX_SIZE),
    .SIZE    (SIZE)
  ) u_addr (
    .clk     (clk),
    .reset   (reset),
    .load    (start),
    .load_val(start_addr),
    .inc     (load),
    .count   (mem_addr0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            remaining <= len_clamped;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (load) begin
            out_data  <= mem_read_data;
            out_valid <= 1'b1;
            remaining <= remaining - (IDX_SIZE + 1)'(1);
          end else if (hs) begin
            out_valid <= 1'b0;
          end
          // Finish once nothing is left to load and the last word is gone.
          if ((remaining == '0) && (!out_valid || hs)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_std_mem_d1_streamer.sv
module tb_std_mem_d1_streamer;
  import std_mem_stream_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT with SIZE=16 ----------------
  logic        go16 = 1'b0;
  logic [3:0]  sa16 = '0;
  logic [4:0]  len16 = '0;
  logic [3:0]  addr16;
  logic [31:0] rd16, data16;
  logic        valid16, busy16, done16;
  logic        ready16 = 1'b1;
  stream_state_e st16;

  assign rd16 = 32'(addr16) + 32'd100;

  std_mem_d1_streamer #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4)) u_dut16 (
    .clk(clk), .reset(reset), .go(go16), .start_addr(sa16), .len(len16),
    .mem_addr0(addr16), .mem_read_data(rd16), .out_data(data16),
    .out_valid(valid16), .out_ready(ready16), .busy(busy16), .done(done16),
    .dbg_state(st16)
  );

  // ---------------- DUT with SIZE=10 ----------------
  logic        go10 = 1'b0;
  logic [3:0]  sa10 = '0;
  logic [4:0]  len10 = '0;
  logic [3:0]  addr10;
  logic [31:0] rd10, data10;
  logic        valid10, busy10, done10;
  logic        ready10 = 1'b1;
  stream_state_e st10;

  assign rd10 = 32'(addr10) + 32'd100;

  std_mem_d1_streamer #(.WIDTH(32), .SIZE(10), .IDX_SIZE(4)) u_dut10 (
    .clk(clk), .reset(reset), .go(go10), .start_addr(sa10), .len(len10),
    .mem_addr0(addr10), .mem_read_data(rd10), .out_data(data10),
    .out_valid(valid10), .out_ready(ready10), .busy(busy10), .done(done10),
    .dbg_state(st10)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp16_q[$];
  logic [31:0] exp10_q[$];
  int hs16 = 0;
  logic stall16 = 1'b0;
  logic [31:0] held16 = '0;
  int t0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the SIZE=16 stream: order, no extras, stability under stall.
  always @(negedge clk) begin
    if (reset) begin
      stall16 = 1'b0;
    end else begin
      if (stall16) begin
        chk("hold_valid16", 32'(valid16), 32'd1);
        chk("hold_data16", data16, held16);
      end
      if (valid16 && ready16) begin
        hs16++;
        chk("q16_nonempty", 32'(exp16_q.size() != 0), 32'd1);
        if (exp16_q.size() != 0) chk("word16", data16, exp16_q.pop_front());
      end
      stall16 = valid16 && !ready16;
      held16  = data16;
    end
  end

  // Monitor for the SIZE=10 stream.
  always @(negedge clk) begin
    if (!reset && valid10 && ready10) begin
      chk("q10_nonempty", 32'(exp10_q.size() != 0), 32'd1);
      if (exp10_q.size() != 0) chk("word10", data10, exp10_q.pop_front());
    end
  end

  // Ready driver: mode 0 always ready, mode 1 repeats 1,0,0,1.
  int ready_mode = 0;
  int pidx = 0;
  logic [3:0] ready_pat = 4'b1001;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) ready16 = 1'b1;
    else begin
      ready16 = ready_pat[pidx % 4];
      pidx++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: the current cycle is cycle 0 of the transfer.
  task automatic start_xfer(input int sel, input logic [3:0] sa, input logic [4:0] ln);
    if (sel == 0) begin go16 = 1'b1; sa16 = sa; len16 = ln; end
    else          begin go10 = 1'b1; sa10 = sa; len10 = ln; end
    t0 = cyc;
    tick();
    go16 = 1'b0;
    go10 = 1'b0;
  endtask

  task automatic push(input int sel, input int first, input int n, input int size);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) exp16_q.push_back(32'(100 + ((first + i) % size)));
      else          exp10_q.push_back(32'(100 + ((first + i) % size)));
    end
  endtask

  task automatic wait_done(input int sel, input int exp_delta);
    int n = 0;
    bit seen = 0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if ((sel == 0) ? done16 : done10) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen && exp_delta >= 0) chk("done_cycle", 32'(cyc - t0), 32'(exp_delta));
    chk("queue_drained", 32'((sel == 0) ? exp16_q.size() : exp10_q.size()), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'((sel == 0) ? done16 : done10), 32'd0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;
    bit ok;

    tick();
    tick();
    chk("rst_valid", 32'(valid16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_addr", 32'(addr16), 32'd0);
    chk("rst_data", data16, 32'd0);
    chk("rst_state", 32'(st16), 32'(IDLE));
    reset = 1'b0;
    tick();

    // Basic: start 3, len 4 -> 103..106 on cycles 2..5, done on 6.
    exp16_q.push_back(32'd103); exp16_q.push_back(32'd104);
    exp16_q.push_back(32'd105); exp16_q.push_back(32'd106);
    start_xfer(0, 4'd3, 5'd4);
    chk("c1_addr", 32'(addr16), 32'd3);
    @(negedge clk);
    chk("c1_valid", 32'(valid16), 32'd0);
    chk("c1_busy", 32'(busy16), 32'd1);
    @(negedge clk);
    chk("c2_valid", 32'(valid16), 32'd1);
    wait_done(0, 6);

    // Wrap on SIZE=16: 114, 115, 100, 101.
    exp16_q.push_back(32'd114); exp16_q.push_back(32'd115);
    exp16_q.push_back(32'd100); exp16_q.push_back(32'd101);
    start_xfer(0, 4'd14, 5'd4);
    wait_done(0, 6);

    // Wrap on SIZE=10: 108, 109, 100.
    exp10_q.push_back(32'd108); exp10_q.push_back(32'd109); exp10_q.push_back(32'd100);
    start_xfer(1, 4'd8, 5'd3);
    wait_done(1, 5);

    // SIZE=10, len 15 clamps to 10 words starting at 7.
    push(1, 7, 10, 10);
    start_xfer(1, 4'd7, 5'd15);
    wait_done(1, 12);

    // Backpressure: ready 1,0,0,1,...
    ready_mode = 1;
    pidx = 0;
    base = hs16;
    push(0, 0, 5, 16);
    start_xfer(0, 4'd0, 5'd5);
    wait_done(0, -1);
    chk("bp_handshakes", 32'(hs16 - base), 32'd5);
    ready_mode = 0;
    tick();

    // len 0: no word, done on cycle 2.
    base = hs16;
    start_xfer(0, 4'd6, 5'd0);
    wait_done(0, 2);
    chk("len0_handshakes", 32'(hs16 - base), 32'd0);

    // len 20 clamps to 16 words.
    base = hs16;
    push(0, 0, 16, 16);
    start_xfer(0, 4'd0, 5'd20);
    wait_done(0, 18);
    chk("len20_handshakes", 32'(hs16 - base), 32'd16);

    // go pulsed during STREAM is ignored.
    push(0, 2, 4, 16);
    start_xfer(0, 4'd2, 5'd4);
    go16 = 1'b1; sa16 = 4'd9; len16 = 5'd3;
    tick();
    go16 = 1'b0;
    wait_done(0, 6);
    tick();
    chk("no_restart_busy", 32'(busy16), 32'd0);

    // Async reset after the second word, then a fresh transfer.
    base = hs16;
    push(0, 0, 8, 16);
    start_xfer(0, 4'd0, 5'd8);
    n = 0;
    ok = 0;
    while (n < 50 && !ok) begin
      @(negedge clk);
      #2;
      n++;
      if (hs16 - base >= 2) ok = 1;
    end
    chk("hs_before_reset", 32'(ok), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid16), 32'd0);
    chk("mid_rst_done", 32'(done16), 32'd0);
    chk("mid_rst_busy", 32'(busy16), 32'd0);
    chk("mid_rst_addr", 32'(addr16), 32'd0);
    exp16_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    exp16_q.push_back(32'd105); exp16_q.push_back(32'd106);
    start_xfer(0, 4'd5, 5'd2);
    chk("post_rst_addr", 32'(addr16), 32'd5);
    wait_done(0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
